// File: rtl/shift_arb_pkg.sv
// ============================================================================
// shift_arb_pkg : lane constants, request record and direction type
// Rev 1.0
// ============================================================================
`default_nettype none

package shift_arb_pkg;

   localparam int LANE_W      = 32;
   localparam int AMT_LANE_W  = 5;
   localparam int SHAMT_BUS_W = 12;
   localparam int DATA_W      = 64;
   localparam int AMT_W       = 6;

   typedef enum logic {
      LEFT  = 1'b0,
      RIGHT = 1'b1
   } dir_e;

   typedef struct packed {
      logic              wide;
      dir_e              dir;
      logic              arith;
      logic [AMT_W-1:0]  amt;
      logic [DATA_W-1:0] data;
   } shift_req_t;

endpackage

`default_nettype wire

// File: rtl/shift64.sv
// ============================================================================
// shift64 : combinational 64-bit shifter, unified or dual 32-bit lane mode
// Rev 1.0
// ============================================================================
`default_nettype none

module shift64 (
   input  logic [63:0] in_bus_i,
   input  logic        mode_unified_i,
   input  logic        uni_dir_i,
   input  logic        uni_arith_i,
   input  logic        lo_dir_i,
   input  logic        lo_arith_i,
   input  logic        hi_dir_i,
   input  logic        hi_arith_i,
   input  logic [11:0] shift_amt_i,
   output logic [63:0] out_bus_o
);

   // Split mode: lo amount in [4:0], hi amount in [10:6]; unified uses [5:0].
   logic w_unused_amt;
   assign w_unused_amt = shift_amt_i[11];

   function automatic logic [31:0] lane_shift(logic [31:0] d, logic dir, logic arith,
                                              logic [4:0] n);
      if (!dir)      return d << n;
      else if (arith) return 32'($signed(d) >>> n);
      else           return d >> n;
   endfunction

   function automatic logic [63:0] uni_shift(logic [63:0] d, logic dir, logic arith,
                                             logic [5:0] n);
      if (!dir)      return d << n;
      else if (arith) return 64'($signed(d) >>> n);
      else           return d >> n;
   endfunction

   always_comb begin
      out_bus_o = '0;
      if (mode_unified_i) begin
         out_bus_o = uni_shift(in_bus_i, uni_dir_i, uni_arith_i, shift_amt_i[5:0]);
      end else begin
         out_bus_o[31:0]  = lane_shift(in_bus_i[31:0], lo_dir_i, lo_arith_i, shift_amt_i[4:0]);
         out_bus_o[63:32] = lane_shift(in_bus_i[63:32], hi_dir_i, hi_arith_i, shift_amt_i[10:6]);
      end
   end

endmodule

`default_nettype wire

// File: rtl/shift_arbiter_slot.sv
// ============================================================================
// shift_rsp_slot : one-entry result register with valid/ready handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module shift_rsp_slot #(
   parameter int DW = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_i,
   input  logic [DW-1:0] data_i,
   input  logic          ready_i,
   output logic          valid_o,
   output logic [DW-1:0] data_o
);

   logic          valid_q, valid_d;
   logic [DW-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/shift_arbiter.sv
// ============================================================================
// shift_arbiter : shares one shift64 between two requesters, fusing 32-bit ops
// Rev 1.0
// ============================================================================
`default_nettype none

module shift_arbiter
   import shift_arb_pkg::*;
#(
   parameter int DW    = 64,
   parameter int AW    = 6,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid_i,
   output logic             req0_ready_o,
   input  logic             req0_wide_i,
   input  logic             req0_dir_i,
   input  logic             req0_arith_i,
   input  logic [AW-1:0]    req0_amt_i,
   input  logic [DW-1:0]    req0_data_i,
   input  logic             req1_valid_i,
   output logic             req1_ready_o,
   input  logic             req1_wide_i,
   input  logic             req1_dir_i,
   input  logic             req1_arith_i,
   input  logic [AW-1:0]    req1_amt_i,
   input  logic [DW-1:0]    req1_data_i,
   output logic             rsp0_valid_o,
   input  logic             rsp0_ready_i,
   output logic [DW-1:0]    rsp0_data_o,
   output logic             rsp1_valid_o,
   input  logic             rsp1_ready_i,
   output logic [DW-1:0]    rsp1_data_o,
   output logic [CNT_W-1:0] issue_cnt_o,
   output logic [CNT_W-1:0] fuse_cnt_o
);

   shift_req_t w_req0, w_req1;
   assign w_req0 = '{wide: req0_wide_i, dir: dir_e'(req0_dir_i), arith: req0_arith_i,
                     amt: req0_amt_i, data: req0_data_i};
   assign w_req1 = '{wide: req1_wide_i, dir: dir_e'(req1_dir_i), arith: req1_arith_i,
                     amt: req1_amt_i, data: req1_data_i};

   logic [1:0]       w_elig, w_grant, w_slot_valid, w_rsp_ready;
   logic             w_fuse;
   logic             rr_q, rr_d;
   logic [CNT_W-1:0] issue_q, issue_d, fuse_q, fuse_d;

   assign w_rsp_ready = {rsp1_ready_i, rsp0_ready_i};
   assign w_elig[0]   = req0_valid_i & (~w_slot_valid[0] | rsp0_ready_i);
   assign w_elig[1]   = req1_valid_i & (~w_slot_valid[1] | rsp1_ready_i);

   // rr_q names the requester that wins a non-fusable conflict.
   assign w_fuse     = ~rst & w_elig[0] & w_elig[1] & ~w_req0.wide & ~w_req1.wide;
   assign w_grant[0] = ~rst & (w_fuse | (w_elig[0] & (~rr_q | ~w_elig[1])));
   assign w_grant[1] = ~rst & (w_fuse | (w_elig[1] & (rr_q | ~w_elig[0])));

   assign req0_ready_o = w_grant[0];
   assign req1_ready_o = w_grant[1];

   logic [63:0]            w_in_bus, w_out_bus;
   logic                   w_unified, w_uni_dir, w_uni_arith;
   logic                   w_lo_dir, w_lo_arith, w_hi_dir, w_hi_arith;
   logic [SHAMT_BUS_W-1:0] w_shamt;

   always_comb begin
      w_in_bus    = '0;
      w_unified   = 1'b0;
      w_uni_dir   = 1'b0;
      w_uni_arith = 1'b0;
      w_lo_dir    = 1'b0;
      w_lo_arith  = 1'b0;
      w_hi_dir    = 1'b0;
      w_hi_arith  = 1'b0;
      w_shamt     = '0;
      if (w_grant[0] & w_req0.wide) begin
         w_unified   = 1'b1;
         w_uni_dir   = (w_req0.dir == RIGHT);
         w_uni_arith = w_req0.arith;
         w_shamt     = {6'b0, w_req0.amt};
         w_in_bus    = w_req0.data;
      end else if (w_grant[1] & w_req1.wide) begin
         w_unified   = 1'b1;
         w_uni_dir   = (w_req1.dir == RIGHT);
         w_uni_arith = w_req1.arith;
         w_shamt     = {6'b0, w_req1.amt};
         w_in_bus    = w_req1.data;
      end else begin
         if (w_grant[0]) begin
            w_lo_dir       = (w_req0.dir == RIGHT);
            w_lo_arith     = w_req0.arith;
            w_shamt[4:0]   = w_req0.amt[AMT_LANE_W-1:0];
            w_in_bus[31:0] = w_req0.data[LANE_W-1:0];
         end
         if (w_grant[1]) begin
            w_hi_dir        = (w_req1.dir == RIGHT);
            w_hi_arith      = w_req1.arith;
            w_shamt[10:6]   = w_req1.amt[AMT_LANE_W-1:0];
            w_in_bus[63:32] = w_req1.data[LANE_W-1:0];
         end
      end
   end

   shift64 u_shift64 (
      .in_bus_i       (w_in_bus),
      .mode_unified_i (w_unified),
      .uni_dir_i      (w_uni_dir),
      .uni_arith_i    (w_uni_arith),
      .lo_dir_i       (w_lo_dir),
      .lo_arith_i     (w_lo_arith),
      .hi_dir_i       (w_hi_dir),
      .hi_arith_i     (w_hi_arith),
      .shift_amt_i    (w_shamt),
      .out_bus_o      (w_out_bus)
   );

   logic [DW-1:0] w_res [2];
   logic [DW-1:0] w_slot_data [2];
   assign w_res[0] = w_req0.wide ? w_out_bus : {32'b0, w_out_bus[31:0]};
   assign w_res[1] = w_req1.wide ? w_out_bus : {32'b0, w_out_bus[63:32]};

   for (genvar g = 0; g < 2; g++) begin : g_slot
      shift_rsp_slot #(.DW(DW)) u_slot (
         .clk     (clk),
         .rst     (rst),
         .load_i  (w_grant[g]),
         .data_i  (w_res[g]),
         .ready_i (w_rsp_ready[g]),
         .valid_o (w_slot_valid[g]),
         .data_o  (w_slot_data[g])
      );
   end

   assign rsp0_valid_o = w_slot_valid[0];
   assign rsp1_valid_o = w_slot_valid[1];
   assign rsp0_data_o  = w_slot_data[0];
   assign rsp1_data_o  = w_slot_data[1];

   always_comb begin
      rr_d    = rr_q;
      issue_d = issue_q;
      fuse_d  = fuse_q;
      if (|w_grant) issue_d = issue_q + CNT_W'(1);
      if (w_fuse)   fuse_d  = fuse_q + CNT_W'(1);
      if (w_grant[0] ^ w_grant[1]) rr_d = w_grant[0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q    <= 1'b0;
         issue_q <= '0;
         fuse_q  <= '0;
      end else begin
         rr_q    <= rr_d;
         issue_q <= issue_d;
         fuse_q  <= fuse_d;
      end
   end

   assign issue_cnt_o = issue_q;
   assign fuse_cnt_o  = fuse_q;

endmodule

`default_nettype wire
